// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory bus between the memory stage and the memory system.
//
// Handshake: the master raises bus_req_o together with stable bus_we_o,
// bus_addr_o, bus_wdata_o and bus_be_o, and holds all of them unchanged
// until the slave answers with a one-cycle bus_ack_i. For reads,
// bus_rdata_i is valid only in the cycle where bus_ack_i is 1. An ack seen
// while no request is pending carries no meaning and is ignored.
//
// Signals:
//   bus_req_o    master->slave  access request
//   bus_we_o     master->slave  1 = write
//   bus_addr_o   master->slave  word address, [1:0] = 00
//   bus_wdata_o  master->slave  lane-replicated store data
//   bus_be_o     master->slave  byte enables
//   bus_ack_i    slave->master  access complete this cycle
//   bus_rdata_i  slave->master  read data (valid with bus_ack_i)
interface mem_stage_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Accepts loads/stores from execute,
// checks alignment, runs a single bus access with a timeout, and returns
// an extended load result for one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   ex_valid_i          execute presents an instruction
//   ex_inst_i           instruction word (only funct3 [14:12] used)
//   ex_mem_rd_i/wr_i    load / store request (both = store)
//   ex_addr_i           effective address
//   ex_wdata_i          store data
//   ex_reg_waddr_i      load destination register
//   bus                 memory bus (mem_stage_if.master)
//   hold_req_o          stall request to pipeline control
//   load_valid_o        one-cycle pulse, load result valid
//   load_data_o         extended load result
//   reg_waddr_o         load destination register
//   misalign_o          one-cycle pulse, misaligned access rejected
//   bus_err_o           one-cycle pulse, bus timeout
//   o_dbg_state         current FSM state (0 IDLE,1 WAIT,2 RESP,3 ERR)
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_inst_i,
  input  logic        ex_mem_rd_i,
  input  logic        ex_mem_wr_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_reg_waddr_i,
  mem_stage_if.master bus,
  output logic        hold_req_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic [4:0]  reg_waddr_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic        r_load_valid;
  logic [31:0] r_load_data;
  logic [4:0]  r_reg_waddr;
  logic        r_misalign;
  logic        r_bus_err;

  logic [2:0]  w_f3;
  logic        w_is_mem;
  logic [1:0]  w_size;
  logic        w_aligned;
  logic        w_accept;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic        w_unused;

  assign w_f3     = ex_inst_i[14:12];
  assign w_is_mem = ex_valid_i & (ex_mem_rd_i | ex_mem_wr_i);
  assign w_unused = ^{ex_inst_i[31:15], ex_inst_i[11:0]};

  // Access size. Stores only know SB/SH/SW; loads add the unsigned
  // variants. Every other funct3 is a word access.
  always_comb begin
    w_size = SZ_WORD;
    if (ex_mem_wr_i) begin
      case (w_f3)
        3'b000:  w_size = SZ_BYTE;
        3'b001:  w_size = SZ_HALF;
        default: w_size = SZ_WORD;
      endcase
    end else begin
      case (w_f3)
        3'b000, 3'b100: w_size = SZ_BYTE;
        3'b001, 3'b101: w_size = SZ_HALF;
        default:        w_size = SZ_WORD;
      endcase
    end
  end

  always_comb begin
    w_aligned = 1'b1;
    w_be      = 4'hF;
    w_wdata   = ex_wdata_i;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << ex_addr_i[1:0];
        w_wdata = {4{ex_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        w_aligned = ~ex_addr_i[0];
        w_be      = 4'b0011 << ex_addr_i[1:0];
        w_wdata   = {2{ex_wdata_i[15:0]}};
      end
      default: begin
        w_aligned = (ex_addr_i[1:0] == 2'b00);
      end
    endcase
  end

  assign w_accept   = w_is_mem & w_aligned;
  assign w_misalign = w_is_mem & ~w_aligned;

  // Lane select: shift the addressed byte/half down to bit 0, then extend.
  assign w_shifted = bus.bus_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_load = bus.bus_rdata_i;
    case (r_size)
      SZ_BYTE: w_load = r_unsigned ? {24'd0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load = r_unsigned ? {16'd0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = bus.bus_rdata_i;
    endcase
  end

  // Stall is raised combinationally in the accept cycle so the pipeline
  // freezes before the op has even reached WAIT.
  assign hold_req_o = ((r_state == S_IDLE) & w_accept) | (r_state == S_WAIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_off        <= 2'd0;
      r_size       <= SZ_WORD;
      r_unsigned   <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= 32'd0;
      r_bus_wdata  <= 32'd0;
      r_bus_be     <= 4'd0;
      r_load_valid <= 1'b0;
      r_load_data  <= 32'd0;
      r_reg_waddr  <= 5'd0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_off       <= ex_addr_i[1:0];
            r_size      <= w_size;
            r_unsigned  <= w_f3[2];
            r_bus_we    <= ex_mem_wr_i;
            r_bus_addr  <= {ex_addr_i[31:2], 2'b00};
            r_bus_wdata <= w_wdata;
            r_bus_be    <= w_be;
            r_reg_waddr <= ex_reg_waddr_i;
            r_bus_req   <= 1'b1;
            r_cnt       <= 8'd0;
            r_state     <= S_WAIT;
          end else if (w_misalign) begin
            r_misalign <= 1'b1;
          end
        end
        S_WAIT: begin
          // Ack is tested first so it wins over a same-cycle timeout.
          if (bus.bus_ack_i) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
              r_load_valid <= 1'b1;
              r_load_data  <= w_load;
            end
            r_state <= S_RESP;
          end else if (r_cnt == TO_LAST) begin
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_req_o   = r_bus_req;
  assign bus.bus_we_o    = r_bus_we;
  assign bus.bus_addr_o  = r_bus_addr;
  assign bus.bus_wdata_o = r_bus_wdata;
  assign bus.bus_be_o    = r_bus_be;
  assign load_valid_o    = r_load_valid;
  assign load_data_o     = r_load_data;
  assign reg_waddr_o     = r_reg_waddr;
  assign misalign_o      = r_misalign;
  assign bus_err_o       = r_bus_err;
  assign o_dbg_state     = r_state;

endmodule
